ray_issue_scheduler: RTL and testbench

//  Frame-level sequencer for ray_generator. On start, walks every pixel in raster order and issues coordinates.

---
 rtl/ray_issue_scheduler_pkg.sv | 35 +++
 rtl/ray_issue_scheduler_if.sv | 27 ++
 rtl/ray_issue_scheduler_fifo.sv | 83 ++++++++
 rtl/ray_issue_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_ray_issue_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ray_issue_scheduler_pkg.sv
// Shared types for the ray issue scheduler: fixed-point container, direction
// vector, pixel coordinate, buffered ray job and the sequencer states.
package ray_issue_scheduler_pkg;

  typedef logic [31:0] fp_t;

  typedef struct packed {
    fp_t x;
    fp_t y;
    fp_t z;
  } vec3_t;

  typedef logic [15:0] pix_coord_t;

  typedef struct packed {
    pix_coord_t x;
    pix_coord_t y;
    vec3_t      dir;
  } ray_job_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } sched_state_e;

  localparam int DEFAULT_SCREEN_WIDTH  = 640;
  localparam int DEFAULT_SCREEN_HEIGHT = 480;

  // Integer pixel coordinate placed in the low half of an fp container, not shifted.
  function automatic fp_t coord_to_fp(input pix_coord_t c);
    return {16'b0, c};
  endfunction

endpackage

// File: rtl/ray_issue_scheduler_if.sv
// Output stream from the scheduler to the ray marcher: one ray job per beat.
interface ray_issue_scheduler_if;
  import ray_issue_scheduler_pkg::*;

  logic       out_valid;
  logic       out_ready;
  pix_coord_t out_pixel_x;
  pix_coord_t out_pixel_y;
  vec3_t      out_ray_dir;

  modport master (
    output out_valid,
    output out_pixel_x,
    output out_pixel_y,
    output out_ray_dir,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_pixel_x,
    input  out_pixel_y,
    input  out_ray_dir,
    output out_ready
  );

endinterface

// File: rtl/ray_issue_scheduler_fifo.sv
// Synchronous FIFO of ray jobs. A pop and a push in the same cycle are both
// accepted even when full. Flush empties the buffer in one cycle.
module ray_job_fifo
  import ray_issue_scheduler_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  ray_job_t      push_data,
  input  logic          pop,
  output ray_job_t      head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  ray_job_t          mem_q [DEPTH];
  ray_job_t          mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              pop_ok;
  logic              push_ok;

  assign pop_ok  = pop && !empty_q;
  assign push_ok = push && (!full_q || pop_ok);

  // Next pointers, occupancy and storage; flags are derived from the next count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  // Storage and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/ray_issue_scheduler.sv
// Frame sequencer for the ray generator: walks pixels in raster order, pairs
// each generated direction with its coordinates through a fixed-latency tag
// line, buffers the jobs and streams them to the marcher under credit control.
module ray_issue_scheduler
  import ray_issue_scheduler_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
  parameter int GEN_LATENCY   = 3,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   frame_done,
  output fp_t                    gen_screen_x,
  output fp_t                    gen_screen_y,
  output logic                   gen_coords_valid,
  input  vec3_t                  gen_ray_dir,
  ray_issue_scheduler_if.master  out_if
);

  localparam int         CW     = $clog2(FIFO_DEPTH) + 1;
  localparam pix_coord_t X_LAST = pix_coord_t'(SCREEN_WIDTH - 1);
  localparam pix_coord_t Y_LAST = pix_coord_t'(SCREEN_HEIGHT - 1);

  sched_state_e         state_q, state_d;
  pix_coord_t           x_q, x_d;
  pix_coord_t           y_q, y_d;
  logic                 gen_valid_q, gen_valid_d;
  pix_coord_t           gen_x_q, gen_x_d;
  pix_coord_t           gen_y_q, gen_y_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic [GEN_LATENCY-1:0] dl_valid_q, dl_valid_d;
  pix_coord_t           dl_x_q [GEN_LATENCY];
  pix_coord_t           dl_x_d [GEN_LATENCY];
  pix_coord_t           dl_y_q [GEN_LATENCY];
  pix_coord_t           dl_y_d [GEN_LATENCY];
  logic [CW-1:0]        inflight_q, inflight_d;

  logic                 fire;
  logic                 push;
  logic                 pop;
  logic                 last_pixel;
  logic                 drain_done;
  logic [CW:0]          committed;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  ray_job_t             push_job;
  ray_job_t             head_job;

  // The strobe register counts as in flight from the fire decision onwards, so
  // the credit compare covers every job that will eventually land in the FIFO.
  assign committed  = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign fire       = (state_q == ST_ISSUE) && (committed < (CW+1)'(FIFO_DEPTH)) && !abort;
  assign push       = dl_valid_q[GEN_LATENCY-1] && !abort;
  assign pop        = out_if.out_ready && !fifo_empty;
  assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);
  assign drain_done = (inflight_q == '0) &&
                      ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));
  assign push_job   = '{x: dl_x_q[GEN_LATENCY-1], y: dl_y_q[GEN_LATENCY-1], dir: gen_ray_dir};

  // Next-state logic for the FSM, raster counters, strobe, tag line and credits.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    gen_valid_d  = 1'b0;
    gen_x_d      = gen_x_q;
    gen_y_d      = gen_y_q;
    frame_done_d = 1'b0;
    dl_valid_d   = '0;
    dl_valid_d[0] = gen_valid_q;
    dl_x_d[0]    = gen_x_q;
    dl_y_d[0]    = gen_y_q;
    for (int i = 1; i < GEN_LATENCY; i++) begin
      dl_valid_d[i] = dl_valid_q[i-1];
      dl_x_d[i]     = dl_x_q[i-1];
      dl_y_d[i]     = dl_y_q[i-1];
    end
    inflight_d = inflight_q + CW'(fire) - CW'(push);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          x_d     = '0;
          y_d     = '0;
        end
      end
      ST_ISSUE: begin
        if (fire) begin
          gen_valid_d = 1'b1;
          gen_x_d     = x_q;
          gen_y_d     = y_q;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 16'd1;
          end else begin
            x_d = x_q + 16'd1;
          end
          if (last_pixel) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d      = ST_IDLE;
      x_d          = '0;
      y_d          = '0;
      gen_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      dl_valid_d   = '0;
      inflight_d   = '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Single register stage for the FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      gen_valid_q  <= 1'b0;
      gen_x_q      <= '0;
      gen_y_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      dl_valid_q   <= '0;
      dl_x_q       <= '{default: '0};
      dl_y_q       <= '{default: '0};
      inflight_q   <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      gen_valid_q  <= gen_valid_d;
      gen_x_q      <= gen_x_d;
      gen_y_q      <= gen_y_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      dl_valid_q   <= dl_valid_d;
      dl_x_q       <= dl_x_d;
      dl_y_q       <= dl_y_d;
      inflight_q   <= inflight_d;
    end
  end

  ray_job_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (push),
    .push_data (push_job),
    .pop       (pop),
    .head      (head_job),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The credit rule must keep the buffer from ever taking a push it cannot hold.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(push && fifo_full && !pop));
    end
  end

  assign busy             = busy_q;
  assign frame_done       = frame_done_q;
  assign gen_coords_valid = gen_valid_q;
  assign gen_screen_x     = coord_to_fp(gen_x_q);
  assign gen_screen_y     = coord_to_fp(gen_y_q);

  assign out_if.out_valid   = !fifo_empty;
  assign out_if.out_pixel_x = head_job.x;
  assign out_if.out_pixel_y = head_job.y;
  assign out_if.out_ray_dir = head_job.dir;

endmodule

// File: tb/tb_ray_issue_scheduler.sv
// Directed bench for the ray issue scheduler on a 4x2 screen with a 3-stage
// behavioural ray generator.
module tb_ray_issue_scheduler;
  import ray_issue_scheduler_pkg::*;

  localparam int W = 4;
  localparam int H = 2;
  localparam int NPIX = W * H;
  localparam vec3_t GARBAGE = '{x: 32'hDEAD_0001, y: 32'hDEAD_0002, z: 32'hDEAD_0003};

  logic  clk;
  logic  rst;
  logic  start;
  logic  abort;
  logic  busy;
  logic  frame_done;
  fp_t   gen_screen_x;
  fp_t   gen_screen_y;
  logic  gen_coords_valid;
  vec3_t gen_ray_dir;

  ray_issue_scheduler_if out_if();

  ray_issue_scheduler #(
    .SCREEN_WIDTH  (W),
    .SCREEN_HEIGHT (H),
    .GEN_LATENCY   (3),
    .FIFO_DEPTH    (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .busy             (busy),
    .frame_done       (frame_done),
    .gen_screen_x     (gen_screen_x),
    .gen_screen_y     (gen_screen_y),
    .gen_coords_valid (gen_coords_valid),
    .gen_ray_dir      (gen_ray_dir),
    .out_if           (out_if)
  );

  int tests_run;
  int tests_failed;
  int cyc;
  int strobes;
  int dones;
  int last_pop_cyc;
  int done_cyc;
  logic done_busy;
  ray_job_t beats[$];
  vec3_t gp1, gp2, gp3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct, easily recognised direction per pixel.
  function automatic vec3_t dir_of(input pix_coord_t x, input pix_coord_t y);
    vec3_t d;
    d.x = 32'h1000_0000 | {16'b0, x};
    d.y = 32'h2000_0000 | {16'b0, y};
    d.z = {8'h30, x[3:0], y[3:0], 16'h00A5};
    return d;
  endfunction

  function automatic ray_job_t expected_job(input int i);
    ray_job_t j;
    j.x   = pix_coord_t'(i % W);
    j.y   = pix_coord_t'(i / W);
    j.dir = dir_of(j.x, j.y);
    return j;
  endfunction

  // Behavioural ray generator: three register stages after the sampling edge.
  always @(posedge clk) begin
    gp1 <= gen_coords_valid ? dir_of(gen_screen_x[15:0], gen_screen_y[15:0]) : GARBAGE;
    gp2 <= gp1;
    gp3 <= gp2;
  end
  assign gen_ray_dir = gp3;

  always @(posedge clk) cyc <= cyc + 1;

  // Beat, strobe and frame_done monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (rst && !abort) begin
      if (out_if.out_valid && out_if.out_ready) begin
        beats.push_back('{x: out_if.out_pixel_x, y: out_if.out_pixel_y, dir: out_if.out_ray_dir});
        last_pop_cyc <= cyc;
      end
      if (gen_coords_valid) strobes <= strobes + 1;
      if (frame_done) begin
        dones     <= dones + 1;
        done_cyc  <= cyc;
        done_busy <= busy;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic clear_monitor();
    beats.delete();
    strobes = 0;
    dones   = 0;
  endtask

  task automatic wait_done(input int max_cycles);
    for (int c = 0; c < max_cycles && dones == 0; c++) tick(1);
    tick(3);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; out_if.out_ready = 1'b0;
    tick(3);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tests_run++;
    if (frame_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
    tests_run++;
    if (gen_coords_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_gen_valid: got %b expected 0", gen_coords_valid); end
    tests_run++;
    if (out_if.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_if.out_valid); end
    tests_run++;
    if ({gen_screen_x, gen_screen_y} !== 64'h0) begin tests_failed++; $display("[TB] FAIL reset_coords: got %h %h expected 0 0", gen_screen_x, gen_screen_y); end
    rst = 1'b1;
    tick(1);
  endtask

  task automatic test_basic_frame();
    ray_job_t exp;
    clear_monitor();
    out_if.out_ready = 1'b1;
    pulse_start();
    wait_done(200);
    tests_run++;
    if (beats.size() != NPIX) begin tests_failed++; $display("[TB] FAIL basic_beat_count: got %0d expected %0d", beats.size(), NPIX); end
    for (int i = 0; i < NPIX && i < beats.size(); i++) begin
      exp = expected_job(i);
      tests_run++;
      if (beats[i] !== exp) begin tests_failed++; $display("[TB] FAIL basic_beat%0d: got %h expected %h", i, beats[i], exp); end
    end
    tests_run++;
    if (dones != 1) begin tests_failed++; $display("[TB] FAIL basic_done_count: got %0d expected 1", dones); end
    tests_run++;
    if (done_cyc != last_pop_cyc + 1) begin tests_failed++; $display("[TB] FAIL basic_done_timing: got cycle %0d expected %0d", done_cyc, last_pop_cyc + 1); end
    tests_run++;
    if (done_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_busy_at_done: got %b expected 0", done_busy); end
    tests_run++;
    if (strobes != NPIX) begin tests_failed++; $display("[TB] FAIL basic_strobes: got %0d expected %0d", strobes, NPIX); end
  endtask

  task automatic test_backpressure();
    ray_job_t exp;
    clear_monitor();
    out_if.out_ready = 1'b0;
    pulse_start();
    tick(30);
    tests_run++;
    if (strobes != 8) begin tests_failed++; $display("[TB] FAIL bp_strobes: got %0d expected 8", strobes); end
    tests_run++;
    if (out_if.out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_out_valid: got %b expected 1", out_if.out_valid); end
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_busy_stalled: got %b expected 1", busy); end
    tests_run++;
    if (beats.size() != 0 || dones != 0) begin tests_failed++; $display("[TB] FAIL bp_no_beats: got beats %0d dones %0d expected 0 0", beats.size(), dones); end
    out_if.out_ready = 1'b1;
    wait_done(200);
    tests_run++;
    if (beats.size() != NPIX) begin tests_failed++; $display("[TB] FAIL bp_beat_count: got %0d expected %0d", beats.size(), NPIX); end
    for (int i = 0; i < NPIX && i < beats.size(); i++) begin
      exp = expected_job(i);
      tests_run++;
      if (beats[i] !== exp) begin tests_failed++; $display("[TB] FAIL bp_beat%0d: got %h expected %h", i, beats[i], exp); end
    end
    tests_run++;
    if (dones != 1) begin tests_failed++; $display("[TB] FAIL bp_done_count: got %0d expected 1", dones); end
  endtask

  task automatic test_toggle_ready();
    ray_job_t exp;
    ray_job_t hold;
    logic     have_hold;
    clear_monitor();
    have_hold = 1'b0;
    hold = '0;
    out_if.out_ready = 1'b0;
    pulse_start();
    for (int c = 0; c < 300 && dones == 0; c++) begin
      out_if.out_ready = ~out_if.out_ready;
      @(negedge clk);
      if (have_hold && out_if.out_valid) begin
        tests_run++;
        if ({out_if.out_pixel_x, out_if.out_pixel_y, out_if.out_ray_dir} !== hold) begin
          tests_failed++;
          $display("[TB] FAIL toggle_stall_stable: got %h expected %h",
                   {out_if.out_pixel_x, out_if.out_pixel_y, out_if.out_ray_dir}, hold);
        end
      end
      have_hold = out_if.out_valid && !out_if.out_ready;
      hold = '{x: out_if.out_pixel_x, y: out_if.out_pixel_y, dir: out_if.out_ray_dir};
      tick(1);
    end
    out_if.out_ready = 1'b1;
    tick(3);
    tests_run++;
    if (beats.size() != NPIX) begin tests_failed++; $display("[TB] FAIL toggle_beat_count: got %0d expected %0d", beats.size(), NPIX); end
    for (int i = 0; i < NPIX && i < beats.size(); i++) begin
      exp = expected_job(i);
      tests_run++;
      if (beats[i] !== exp) begin tests_failed++; $display("[TB] FAIL toggle_beat%0d: got %h expected %h", i, beats[i], exp); end
    end
    tests_run++;
    if (dones != 1) begin tests_failed++; $display("[TB] FAIL toggle_done_count: got %0d expected 1", dones); end
  endtask

  task automatic test_abort();
    ray_job_t exp;
    int       issued;
    int       beats_at_abort;
    clear_monitor();
    issued = 0;
    out_if.out_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 50 && issued < 4; c++) begin
      if (gen_coords_valid) issued++;
      if (issued < 4) tick(1);
    end
    tests_run++;
    if (issued != 4) begin tests_failed++; $display("[TB] FAIL abort_reach_4th_issue: got %0d expected 4", issued); end
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    beats_at_abort = beats.size();
    tests_run++;
    if (out_if.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_out_valid: got %b expected 0", out_if.out_valid); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    tick(12);
    tests_run++;
    if (dones != 0 || beats.size() != beats_at_abort) begin
      tests_failed++;
      $display("[TB] FAIL abort_quiet: got dones %0d beats %0d expected 0 %0d", dones, beats.size(), beats_at_abort);
    end
    clear_monitor();
    pulse_start();
    wait_done(200);
    tests_run++;
    if (beats.size() != NPIX) begin tests_failed++; $display("[TB] FAIL abort_restart_count: got %0d expected %0d", beats.size(), NPIX); end
    for (int i = 0; i < NPIX && i < beats.size(); i++) begin
      exp = expected_job(i);
      tests_run++;
      if (beats[i] !== exp) begin tests_failed++; $display("[TB] FAIL abort_restart_beat%0d: got %h expected %h", i, beats[i], exp); end
    end
  endtask

  task automatic test_start_while_busy();
    ray_job_t exp;
    clear_monitor();
    out_if.out_ready = 1'b1;
    pulse_start();
    tick(3);
    pulse_start();
    tick(5);
    pulse_start();
    wait_done(200);
    tick(10);
    tests_run++;
    if (beats.size() != NPIX) begin tests_failed++; $display("[TB] FAIL busy_start_count: got %0d expected %0d", beats.size(), NPIX); end
    for (int i = 0; i < NPIX && i < beats.size(); i++) begin
      exp = expected_job(i);
      tests_run++;
      if (beats[i] !== exp) begin tests_failed++; $display("[TB] FAIL busy_start_beat%0d: got %h expected %h", i, beats[i], exp); end
    end
    tests_run++;
    if (dones != 1 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL busy_start_single_frame: got dones %0d busy %b expected 1 0", dones, busy); end
    clear_monitor();
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL start_abort_busy: got %b expected 0", busy); end
    tick(10);
    tests_run++;
    if (strobes != 0 || beats.size() != 0) begin tests_failed++; $display("[TB] FAIL start_abort_idle: got strobes %0d beats %0d expected 0 0", strobes, beats.size()); end
  endtask

  task automatic test_reset_midframe();
    out_if.out_ready = 1'b1;
    clear_monitor();
    pulse_start();
    tick(6);
    rst = 1'b0;
    tick(1);
    tests_run++;
    if ({busy, frame_done, gen_coords_valid, out_if.out_valid} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL midreset_flags: got %b expected 0000", {busy, frame_done, gen_coords_valid, out_if.out_valid});
    end
    tests_run++;
    if ({gen_screen_x, gen_screen_y} !== 64'h0) begin tests_failed++; $display("[TB] FAIL midreset_coords: got %h %h expected 0 0", gen_screen_x, gen_screen_y); end
    rst = 1'b1;
    clear_monitor();
    tick(20);
    tests_run++;
    if (beats.size() != 0 || strobes != 0 || dones != 0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_quiet: got beats %0d strobes %0d dones %0d expected 0 0 0", beats.size(), strobes, dones);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    cyc = 0;
    strobes = 0;
    dones = 0;
    last_pop_cyc = 0;
    done_cyc = 0;
    done_busy = 1'b0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_toggle_ready();
    test_abort();
    test_start_while_busy();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
